// File: rtl/regfile_dump_reader_if.sv
// Stream interface carrying tagged register-file words to the trace/UART path.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_idx;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register file dump reader: on a start pulse, walks FIRST_REG..LAST_REG through a
// spare combinational read port and streams each word, tagged with its index,
// over a valid/ready interface. One word per two cycles without backpressure.
module regfile_dump_reader #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  regfile_dump_reader_if.master strm
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  logic [1:0] state;
  logic [4:0] idx;

  // The read address is the walk index itself, so it stays stable through HOLD.
  assign rf_addr = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // Dump sequencer: READ captures the combinational regfile word, HOLD waits for
  // the consumer, and the last accepted beat passes through DONE back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= 5'd0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_idx   <= 5'd0;
      strm.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= FIRST_IDX;
            state <= READ;
          end
        end
        READ: begin
          strm.out_data  <= rf_data;
          strm.out_idx   <= idx;
          strm.out_last  <= (idx == LAST_IDX);
          strm.out_valid <= 1'b1;
          state          <= HOLD;
        end
        HOLD: begin
          if (strm.out_valid && strm.out_ready) begin
            strm.out_valid <= 1'b0;
            if (strm.out_last) begin
              strm.out_last <= 1'b0;
              state         <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a behavioural 32x32 regfile with a
// posedge write port and combinational reads feeds two readers, one dumping
// x1..x31 and one dumping only x0.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset;
  logic        startA;
  logic        startB;
  logic        busyA;
  logic        busyB;
  logic        doneA;
  logic        doneB;
  logic [4:0]  addrA;
  logic [4:0]  addrB;
  logic [31:0] rfDataA;
  logic [31:0] rfDataB;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] regs [32];
  logic [31:0] expVal [32];

  logic        clrCnt;
  int          beatCount;
  int          doneCount;
  int          passCount;
  int          totalChecks;

  regfile_dump_reader_if #(.DATA_W(32)) vA ();
  regfile_dump_reader_if #(.DATA_W(32)) vB ();

  regfile_dump_reader #(.FIRST_REG(1), .LAST_REG(31), .DATA_W(32)) dutA (
    .clk(clk), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
    .rf_addr(addrA), .rf_data(rfDataA), .strm(vA.master)
  );

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(0), .DATA_W(32)) dutB (
    .clk(clk), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
    .rf_addr(addrB), .rf_data(rfDataB), .strm(vB.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rfDataA = (addrA == 5'd0) ? 32'd0 : regs[addrA];
  assign rfDataB = (addrB == 5'd0) ? 32'd0 : regs[addrB];

  // Regfile write port, registered on the same edge the reader samples.
  always @(posedge clk) begin
    if (we && (wa != 5'd0)) regs[wa] <= wd;
  end

  // Counts accepted beats and DONE cycles of the main reader since the last clear.
  always @(posedge clk) begin
    if (clrCnt) begin
      beatCount <= 0;
      doneCount <= 0;
    end else begin
      if (vA.out_valid && vA.out_ready) beatCount <= beatCount + 1;
      if (doneA) doneCount <= doneCount + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    we = 1'b1;
    wa = addr;
    wd = data;
    step();
    we = 1'b0;
  endtask

  // One dump on reader A, with optional backpressure, extra start pulses,
  // mid-dump reset, and a regfile write to x5 in HOLD (mode 1) or READ (mode 2).
  task automatic applyStimulus(input string name, input int stallIdx, input bit pokeStart,
                               input int abortIdx, input int wrMode, input int wrBeat);
    clrCnt = 1'b1;
    step();
    clrCnt = 1'b0;
    vA.out_ready = 1'b1;
    startA = 1'b1;
    step();
    startA = 1'b0;
    checkOutput({name, " busyAfterStart"}, busyA, 1);
    checkOutput({name, " validInFirstRead"}, vA.out_valid, 0);
    checkOutput({name, " addrFirst"}, addrA, 1);
    step();
    for (int i = 1; i <= 31; i++) begin
      checkOutput($sformatf("%s valid%0d", name, i), vA.out_valid, 1);
      if (abortIdx == i) begin
        #2 reset = 1'b1;
        #1;
        checkOutput({name, " abortValid"}, vA.out_valid, 0);
        checkOutput({name, " abortBusy"}, busyA, 0);
        checkOutput({name, " abortAddr"}, addrA, 0);
        checkOutput({name, " abortDone"}, doneA, 0);
        step();
        reset = 1'b0;
        step();
        step();
        checkOutput({name, " abortNoDone"}, doneCount, 0);
        checkOutput({name, " abortIdle"}, busyA, 0);
        return;
      end
      checkOutput($sformatf("%s idx%0d", name, i), vA.out_idx, i);
      checkOutput($sformatf("%s data%0d", name, i), vA.out_data, expVal[i]);
      checkOutput($sformatf("%s last%0d", name, i), vA.out_last, (i == 31));
      if (stallIdx == i) begin
        vA.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          step();
          checkOutput($sformatf("%s stallValid%0d", name, c), vA.out_valid, 1);
          checkOutput($sformatf("%s stallData%0d", name, c), vA.out_data, expVal[i]);
          checkOutput($sformatf("%s stallIdx%0d", name, c), vA.out_idx, i);
          checkOutput($sformatf("%s stallAddr%0d", name, c), addrA, i);
        end
        vA.out_ready = 1'b1;
      end
      if (pokeStart && i == 7) startA = 1'b1;
      if (wrMode == 1 && wrBeat == i) begin
        we = 1'b1;
        wa = 5'd5;
        wd = 32'hDEAD_BEEF;
      end
      step();
      startA = 1'b0;
      we = 1'b0;
      if (i < 31) begin
        checkOutput($sformatf("%s readGap%0d", name, i), vA.out_valid, 0);
        checkOutput($sformatf("%s addrNext%0d", name, i), addrA, i + 1);
        if (wrMode == 2 && wrBeat == i + 1) begin
          we = 1'b1;
          wa = 5'd5;
          wd = 32'hDEAD_BEEF;
        end
        step();
        we = 1'b0;
      end
    end
    checkOutput({name, " donePulse"}, doneA, 1);
    checkOutput({name, " busyInDone"}, busyA, 1);
    checkOutput({name, " lastCleared"}, vA.out_last, 0);
    checkOutput({name, " validAfterLast"}, vA.out_valid, 0);
    if (pokeStart) startA = 1'b1;
    step();
    startA = 1'b0;
    checkOutput({name, " doneLow"}, doneA, 0);
    checkOutput({name, " busyLow"}, busyA, 0);
    step();
    step();
    checkOutput({name, " stillIdle"}, busyA, 0);
    checkOutput({name, " beatTotal"}, beatCount, 31);
    checkOutput({name, " doneTotal"}, doneCount, 1);
  endtask

  initial begin
    passCount    = 0;
    totalChecks  = 0;
    reset        = 1'b0;
    startA       = 1'b0;
    startB       = 1'b0;
    we           = 1'b0;
    wa           = 5'd0;
    wd           = 32'd0;
    clrCnt       = 1'b1;
    vA.out_ready = 1'b0;
    vB.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) expVal[i] = 32'h1000_0000 + i;
    expVal[0] = 32'd0;

    #2 reset = 1'b1;
    #1;
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    checkOutput("rstValid", vA.out_valid, 0);
    checkOutput("rstLast", vA.out_last, 0);
    checkOutput("rstData", vA.out_data, 0);
    checkOutput("rstIdx", vA.out_idx, 0);
    checkOutput("rstAddr", addrA, 0);
    checkOutput("rstBusyB", busyB, 0);
    step();
    step();
    reset = 1'b0;
    clrCnt = 1'b0;

    for (int i = 1; i < 32; i++) writeReg(5'(i), 32'h1000_0000 + i);
    step();
    checkOutput("idleNoStart", busyA, 0);

    applyStimulus("t1", 0, 1'b0, 0, 0, 0);
    applyStimulus("t2", 3, 1'b1, 0, 0, 0);
    applyStimulus("t4abort", 0, 1'b0, 10, 0, 0);
    applyStimulus("t4redo", 0, 1'b0, 0, 0, 0);

    startB = 1'b1;
    step();
    startB = 1'b0;
    checkOutput("t5busy", busyB, 1);
    checkOutput("t5addr", addrB, 0);
    step();
    checkOutput("t5valid", vB.out_valid, 1);
    checkOutput("t5data", vB.out_data, 0);
    checkOutput("t5idx", vB.out_idx, 0);
    checkOutput("t5last", vB.out_last, 1);
    step();
    checkOutput("t5done", doneB, 1);
    checkOutput("t5validLow", vB.out_valid, 0);
    step();
    checkOutput("t5doneLow", doneB, 0);
    checkOutput("t5busyLow", busyB, 0);

    expVal[5] = 32'h1000_0005;
    applyStimulus("t6read", 0, 1'b0, 0, 2, 5);
    writeReg(5'd5, 32'h1000_0005);
    expVal[5] = 32'hDEAD_BEEF;
    applyStimulus("t6hold", 0, 1'b0, 0, 1, 2);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
